// File: rtl/threshold_config_sequencer_pkg.sv
// Shared trigger package: host command encodings, sequencer state encoding
// and the default trigger channel count.
package threshold_config_sequencer_pkg;

  localparam int NUM_CH_DEFAULT = 40;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_BCAST   = 2'b10,
    OP_RESTART = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_BCAST     = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESTART   = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/threshold_config_sequencer_cfg_cycle_counter.sv
// Loadable down-counter shared by the timed sequencer states; last flags the
// final cycle of the loaded interval.
module cfg_cycle_counter
  import threshold_config_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         last
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = W'(0);

  logic [W-1:0] count_r;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != ZERO)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r <= ONE);

endmodule

// File: rtl/threshold_config_sequencer.sv
// Host-facing sequencer that turns threshold write/read/broadcast/restart
// commands into strobe and control sequences for the filter/trigger datapath.
module threshold_config_sequencer
  import threshold_config_sequencer_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEFAULT,
  parameter int RD_LAT        = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_ch,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        flt_write_threshold_value,
  output logic [7:0]  flt_threshold_ch,
  output logic [31:0] flt_threshold_value,
  input  logic [31:0] flt_threshold_value_read,
  output logic        flt_n_1_reset,
  output logic        flt_enable,
  output logic        busy
);

  state_e           state_r;
  logic             restart_enable_r;
  logic             ch_in_range_s;
  logic             accept_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_load_value_s;
  logic             cnt_en_s;
  logic             cnt_last_s;

  assign ch_in_range_s = (32'(cmd_ch) < 32'(NUM_CH));
  assign accept_s      = cmd_valid & cmd_ready;

  // Arm the shared counter with the interval length of the accepted command.
  always_comb begin
    cnt_load_s       = 1'b0;
    cnt_load_value_s = CNT_W'(0);
    if (accept_s) begin
      case (cmd_op_e'(cmd_op))
        OP_READ: begin
          cnt_load_s       = ch_in_range_s;
          cnt_load_value_s = CNT_W'(RD_LAT);
        end
        OP_BCAST: begin
          cnt_load_s       = 1'b1;
          cnt_load_value_s = CNT_W'(NUM_CH);
        end
        OP_RESTART: begin
          cnt_load_s       = 1'b1;
          cnt_load_value_s = CNT_W'(SETTLE_CYCLES);
        end
        default: begin
          cnt_load_s       = 1'b0;
          cnt_load_value_s = CNT_W'(0);
        end
      endcase
    end else begin
      cnt_load_s       = 1'b0;
      cnt_load_value_s = CNT_W'(0);
    end
  end

  // Count only while in a timed state.
  always_comb begin
    cnt_en_s = 1'b0;
    case (state_r)
      ST_READ_WAIT, ST_BCAST, ST_RESTART: cnt_en_s = 1'b1;
      default:                            cnt_en_s = 1'b0;
    endcase
  end

  cfg_cycle_counter #(
    .W (CNT_W)
  ) u_cfg_cycle_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (cnt_load_value_s),
    .en         (cnt_en_s),
    .last       (cnt_last_s)
  );

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r                   <= ST_IDLE;
      restart_enable_r          <= 1'b0;
      cmd_ready                 <= 1'b1;
      busy                      <= 1'b0;
      rsp_valid                 <= 1'b0;
      rsp_data                  <= 32'd0;
      rsp_err                   <= 1'b0;
      flt_write_threshold_value <= 1'b0;
      flt_threshold_ch          <= 8'd0;
      flt_threshold_value       <= 32'd0;
      flt_n_1_reset             <= 1'b0;
      flt_enable                <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op_e'(cmd_op))
              OP_WRITE: begin
                if (ch_in_range_s) begin
                  state_r                   <= ST_WRITE;
                  flt_write_threshold_value <= 1'b1;
                  flt_threshold_ch          <= cmd_ch;
                  flt_threshold_value       <= cmd_data;
                end else begin
                  state_r   <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= 32'd0;
                end
              end
              OP_READ: begin
                if (ch_in_range_s) begin
                  state_r          <= ST_READ_WAIT;
                  flt_threshold_ch <= cmd_ch;
                end else begin
                  state_r   <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= 32'd0;
                end
              end
              OP_BCAST: begin
                state_r                   <= ST_BCAST;
                flt_write_threshold_value <= 1'b1;
                flt_threshold_ch          <= 8'd0;
                flt_threshold_value       <= cmd_data;
              end
              OP_RESTART: begin
                state_r          <= ST_RESTART;
                restart_enable_r <= cmd_data[0];
                flt_enable       <= 1'b0;
                flt_n_1_reset    <= 1'b1;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_WRITE: begin
          flt_write_threshold_value <= 1'b0;
          state_r                   <= ST_RESP;
          rsp_valid                 <= 1'b1;
          rsp_err                   <= 1'b0;
          rsp_data                  <= 32'd0;
        end
        ST_BCAST: begin
          // The counter ends the run on NUM_CH-1, so the channel never wraps.
          if (cnt_last_s) begin
            flt_write_threshold_value <= 1'b0;
            state_r                   <= ST_RESP;
            rsp_valid                 <= 1'b1;
            rsp_err                   <= 1'b0;
            rsp_data                  <= 32'd0;
          end else begin
            flt_threshold_ch <= flt_threshold_ch + 8'd1;
          end
        end
        ST_READ_WAIT: begin
          if (cnt_last_s) begin
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= flt_threshold_value_read;
          end
        end
        ST_RESTART: begin
          if (cnt_last_s) begin
            flt_n_1_reset <= 1'b0;
            flt_enable    <= restart_enable_r;
            state_r       <= ST_RESP;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b0;
            rsp_data      <= 32'd0;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= 32'd0;
        end
        default: begin
          state_r                   <= ST_IDLE;
          cmd_ready                 <= 1'b1;
          busy                      <= 1'b0;
          rsp_valid                 <= 1'b0;
          flt_write_threshold_value <= 1'b0;
          flt_n_1_reset             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_config_sequencer.sv
// Directed, table-driven bench for threshold_config_sequencer with a
// one-cycle-latency threshold memory standing in for the datapath.
module tb_threshold_config_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_ch = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        strobe;
  logic [7:0]  thr_ch;
  logic [31:0] thr_value;
  logic [31:0] thr_read;
  logic        n1_reset;
  logic        enable;
  logic        busy;

  int checks = 0;
  int failures = 0;

  threshold_config_sequencer #(
    .NUM_CH        (40),
    .RD_LAT        (2),
    .SETTLE_CYCLES (16)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .cmd_valid                 (cmd_valid),
    .cmd_ready                 (cmd_ready),
    .cmd_op                    (cmd_op),
    .cmd_ch                    (cmd_ch),
    .cmd_data                  (cmd_data),
    .rsp_valid                 (rsp_valid),
    .rsp_data                  (rsp_data),
    .rsp_err                   (rsp_err),
    .flt_write_threshold_value (strobe),
    .flt_threshold_ch          (thr_ch),
    .flt_threshold_value       (thr_value),
    .flt_threshold_value_read  (thr_read),
    .flt_n_1_reset             (n1_reset),
    .flt_enable                (enable),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  // Datapath model: threshold memory with registered readback.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      thr_read <= 32'd0;
    end else begin
      if (strobe) mem[thr_ch] <= thr_value;
      thr_read <= mem[thr_ch];
    end
  end

  // Free-running activity counters sampled on the datapath's clock edge.
  int strobe_total = 0;
  int starts_total = 0;
  int breaks_total = 0;
  int n1_total = 0;
  int en_during_n1 = 0;
  logic [7:0] start_ch = 8'd0;
  logic       prev_strobe = 1'b0;
  logic [7:0] prev_ch = 8'd0;
  always @(posedge clk) begin
    if (strobe) begin
      strobe_total <= strobe_total + 1;
      if (!prev_strobe) begin
        starts_total <= starts_total + 1;
        start_ch     <= thr_ch;
      end else if (thr_ch != prev_ch + 8'd1) begin
        breaks_total <= breaks_total + 1;
      end
    end
    if (n1_reset) n1_total <= n1_total + 1;
    if (n1_reset && enable) en_during_n1 <= en_during_n1 + 1;
    prev_strobe <= strobe;
    prev_ch     <= thr_ch;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      failures++;
      $display("FAIL %s_ready_timeout actual=0 required=1", name);
    end
  endtask

  // Results captured by run_cmd at the response cycle.
  int          got_lat, d_strobes, d_starts, d_breaks, d_n1;
  logic        got_err, got_en, got_n1, got_busy;
  logic [31:0] got_rdata;
  logic [7:0]  got_ch, got_start_ch;

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] ch,
                         input logic [31:0] data);
    int s0, st0, b0, n0;
    wait_ready(name);
    s0 = strobe_total; st0 = starts_total; b0 = breaks_total; n0 = n1_total;
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_data = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 200) begin
      @(posedge clk);
      #1;
      got_lat++;
    end
    got_err = rsp_err; got_rdata = rsp_data; got_ch = thr_ch;
    got_en = enable; got_n1 = n1_reset; got_busy = busy; got_start_ch = start_ch;
    d_strobes = strobe_total - s0; d_starts = starts_total - st0;
    d_breaks = breaks_total - b0; d_n1 = n1_total - n0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  ch;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_strobes;
    logic [7:0]  exp_ch;
    int          exp_n1;
    logic        exp_en;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n, rsp_seen, s0;
    string nm;
    //                op     ch      data              err   rdata             lat str ch     n1  en
    vecs[0]  = '{2'b00, 8'd5,   -32'sd1234,        1'b0, 32'd0,            2,  1,  8'd5,  0,  1'b0};
    vecs[1]  = '{2'b01, 8'd5,   32'd0,             1'b0, -32'sd1234,       3,  0,  8'd5,  0,  1'b0};
    vecs[2]  = '{2'b10, 8'd0,   32'd500,           1'b0, 32'd0,            41, 40, 8'd39, 0,  1'b0};
    vecs[3]  = '{2'b01, 8'd0,   32'd0,             1'b0, 32'd500,          3,  0,  8'd0,  0,  1'b0};
    vecs[4]  = '{2'b01, 8'd39,  32'd0,             1'b0, 32'd500,          3,  0,  8'd39, 0,  1'b0};
    vecs[5]  = '{2'b00, 8'd40,  32'd99,            1'b1, 32'd0,            1,  0,  8'd39, 0,  1'b0};
    vecs[6]  = '{2'b01, 8'd255, 32'd0,             1'b1, 32'd0,            1,  0,  8'd39, 0,  1'b0};
    vecs[7]  = '{2'b00, 8'd39,  32'h7fff_ffff,     1'b0, 32'd0,            2,  1,  8'd39, 0,  1'b0};
    vecs[8]  = '{2'b01, 8'd39,  32'd0,             1'b0, 32'h7fff_ffff,    3,  0,  8'd39, 0,  1'b0};
    vecs[9]  = '{2'b11, 8'd0,   32'd1,             1'b0, 32'd0,            17, 0,  8'd39, 16, 1'b1};
    vecs[10] = '{2'b11, 8'd0,   32'd0,             1'b0, 32'd0,            17, 0,  8'd39, 16, 1'b0};
    vecs[11] = '{2'b11, 8'd7,   32'hffff_fff1,     1'b0, 32'd0,            17, 0,  8'd39, 16, 1'b1};

    // Reset state after the first reset edge.
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_ch", 32'(thr_ch), 32'd0);
    check("rst_value", thr_value, 32'd0);
    check("rst_n1_enable", {30'd0, n1_reset, enable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      nm = $sformatf("v%0d", i);
      run_cmd(nm, vecs[i].op, vecs[i].ch, vecs[i].data);
      check({nm, "_latency"}, 32'(got_lat), 32'(vecs[i].exp_lat));
      check({nm, "_err"}, 32'(got_err), 32'(vecs[i].exp_err));
      check({nm, "_rsp_data"}, got_rdata, vecs[i].exp_rdata);
      check({nm, "_strobes"}, 32'(d_strobes), 32'(vecs[i].exp_strobes));
      check({nm, "_ch"}, 32'(got_ch), 32'(vecs[i].exp_ch));
      check({nm, "_n1_cycles"}, 32'(d_n1), 32'(vecs[i].exp_n1));
      check({nm, "_enable"}, 32'(got_en), 32'(vecs[i].exp_en));
      check({nm, "_n1_at_rsp"}, 32'(got_n1), 32'd0);
      check({nm, "_busy_at_rsp"}, 32'(got_busy), 32'd1);
      if (vecs[i].exp_strobes > 0) begin
        check({nm, "_strobe_runs"}, 32'(d_starts), 32'd1);
        check({nm, "_ch_breaks"}, 32'(d_breaks), 32'd0);
        check({nm, "_start_ch"}, 32'(got_start_ch),
              (vecs[i].op == 2'b10) ? 32'd0 : 32'(vecs[i].ch));
      end
      @(posedge clk);
      #1;
      check({nm, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    end

    // Reset in the middle of a broadcast, at channel 17.
    wait_ready("bcast_rst");
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_ch = 8'd0; cmd_data = 32'd777;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(strobe && thr_ch == 8'd17) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bcast_reached_ch17", {31'd0, strobe && thr_ch == 8'd17}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_strobe", 32'(strobe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    check("midrst_ch", 32'(thr_ch), 32'd0);
    check("midrst_value", thr_value, 32'd0);
    check("midrst_n1_enable", {30'd0, n1_reset, enable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    s0 = strobe_total;
    rsp_seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) rsp_seen++;
    end
    check("midrst_no_rsp", 32'(rsp_seen), 32'd0);
    check("midrst_no_strobe", 32'(strobe_total - s0), 32'd0);

    // A command presented while busy is dropped, not queued.
    wait_ready("busy_ignore");
    s0 = strobe_total;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_ch = 8'd7; cmd_data = 32'd11;
    @(posedge clk);
    #1;
    cmd_ch = 8'd8; cmd_data = 32'd22;
    @(posedge clk);
    #1;
    check("busy_rsp_valid", 32'(rsp_valid), 32'd1);
    check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("busy_strobes", 32'(strobe_total - s0), 32'd1);
    run_cmd("busy_rd8", 2'b01, 8'd8, 32'd0);
    check("busy_rd8_data", got_rdata, 32'd0);
    run_cmd("busy_rd7", 2'b01, 8'd7, 32'd0);
    check("busy_rd7_data", got_rdata, 32'd11);

    check("enable_low_during_n1", 32'(en_during_n1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
